// File: rtl/dii_packet_arbiter_if.sv
// Bundles the arbiter's per-port DII input streams, the arbitrated output
// stream and the grant/busy status into one interface.
//   master : drives input beats and out_ready; observes ready, out_*, grant, busy
//   slave  : the arbiter side of the same signals
interface dii_packet_arbiter_if #(
  parameter int unsigned PORTS = 2
);
  localparam int unsigned DATA_W = 16;

  logic [PORTS*DATA_W-1:0] in_flat_data;
  logic [PORTS-1:0]        in_flat_valid;
  logic [PORTS-1:0]        in_flat_first;
  logic [PORTS-1:0]        in_flat_last;
  logic [PORTS-1:0]        in_flat_ready;

  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_first;
  logic                    out_last;
  logic                    out_ready;

  logic [PORTS-1:0]        grant;
  logic                    busy;

  modport master (
    output in_flat_data, in_flat_valid, in_flat_first, in_flat_last, out_ready,
    input  in_flat_ready, out_data, out_valid, out_first, out_last, grant, busy
  );

  modport slave (
    input  in_flat_data, in_flat_valid, in_flat_first, in_flat_last, out_ready,
    output in_flat_ready, out_data, out_valid, out_first, out_last, grant, busy
  );
endinterface

// File: rtl/dii_packet_arbiter.sv
// Packet-level round-robin arbiter for PORTS DII input streams (1..16).
// A port is locked from its first accepted beat until a beat with last=1 is
// accepted; the output stage is a single-entry register.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - slave modport: per-port in_flat_* beats/ready, out_* stream,
//          out_ready back-pressure, one-hot grant and busy status
module dii_packet_arbiter #(
  parameter int unsigned PORTS = 2
) (
  input logic                clk,
  input logic                rst,
  dii_packet_arbiter_if.slave bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PTR_W  = (PORTS > 1) ? $clog2(PORTS) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state_q,     state_d;
  logic [PTR_W-1:0]  rr_ptr_q,    rr_ptr_d;
  logic [PORTS-1:0]  grant_q,     grant_d;
  logic              out_valid_q, out_valid_d;
  logic              out_first_q, out_first_d;
  logic              out_last_q,  out_last_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;

  logic              skid_ready_c;
  logic              accept_c;
  logic              g_valid_c;
  logic              g_first_c;
  logic              g_last_c;
  logic [DATA_W-1:0] g_data_c;
  logic [PTR_W-1:0]  g_next_ptr_c;
  logic [PORTS-1:0]  pick_c;
  logic              pick_found_c;

  // Output register can take a beat when empty or when it drains this cycle.
  assign skid_ready_c = !out_valid_q || bus.out_ready;

  // Beat of the granted port (grant is one-hot, so an AND-OR mux suffices)
  // and the round-robin pointer that follows it.
  always_comb begin
    g_data_c     = '0;
    g_next_ptr_c = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant_q[i]) begin
        g_data_c     = g_data_c | bus.in_flat_data[i*DATA_W +: DATA_W];
        g_next_ptr_c = PTR_W'((i + 1) % PORTS);
      end
    end
  end

  assign g_valid_c = |(bus.in_flat_valid & grant_q);
  assign g_first_c = |(bus.in_flat_first & grant_q);
  assign g_last_c  = |(bus.in_flat_last  & grant_q);

  assign accept_c  = (state_q == ST_LOCKED) && g_valid_c && skid_ready_c;

  // First valid port at or after rr_ptr, wrapping modulo PORTS.
  always_comb begin
    pick_c       = '0;
    pick_found_c = 1'b0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (!pick_found_c && bus.in_flat_valid[i] &&
            (((32'(rr_ptr_q) + k) % PORTS) == i)) begin
          pick_c[i]    = 1'b1;
          pick_found_c = 1'b1;
        end
      end
    end
  end

  // Next-state logic: packet lock FSM plus the independent output register.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (|bus.in_flat_valid) begin
          state_d = ST_LOCKED;
          grant_d = pick_c;
        end
      end
      ST_LOCKED: begin
        // Lock only releases on an accepted last beat; a stalled port keeps it.
        if (accept_c && g_last_c) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = g_next_ptr_c;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    // Output register drains regardless of FSM state; data stays stable.
    if (accept_c) begin
      out_valid_d = 1'b1;
      out_first_d = g_first_c;
      out_last_d  = g_last_c;
      out_data_d  = g_data_c;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Only the granted port sees ready, and only while locked.
  assign bus.in_flat_ready = (state_q == ST_LOCKED && skid_ready_c) ? grant_q : '0;
  assign bus.out_data      = out_data_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_first     = out_first_q;
  assign bus.out_last      = out_last_q;
  assign bus.grant         = grant_q;
  assign bus.busy          = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Testbench for dii_packet_arbiter: a 4-port instance driven directly and a
// 2-port instance that mirrors ports 0..1 of the same stimulus.
module tb_dii_packet_arbiter;

  typedef struct packed {
    logic [15:0] d;
    logic        f;
    logic        l;
  } beat_t;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  beat_t srcq [4][$];

  dii_packet_arbiter_if #(.PORTS(4)) bus4 ();
  dii_packet_arbiter_if #(.PORTS(2)) bus2 ();

  assign bus2.in_flat_data  = bus4.in_flat_data[31:0];
  assign bus2.in_flat_valid = bus4.in_flat_valid[1:0];
  assign bus2.in_flat_first = bus4.in_flat_first[1:0];
  assign bus2.in_flat_last  = bus4.in_flat_last[1:0];
  assign bus2.out_ready     = bus4.out_ready;

  dii_packet_arbiter #(.PORTS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  dii_packet_arbiter #(.PORTS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus4.in_flat_valid = '0;
    bus4.in_flat_first = '0;
    bus4.in_flat_last  = '0;
    bus4.in_flat_data  = '0;
  endtask

  task automatic drive_beat(input int p, input logic v, input logic f, input logic l,
                            input logic [15:0] d);
    bus4.in_flat_valid[p]        = v;
    bus4.in_flat_first[p]        = f;
    bus4.in_flat_last[p]         = l;
    bus4.in_flat_data[p*16 +: 16] = d;
  endtask

  // Leaves the caller at a falling edge with reset just released.
  task automatic do_reset();
    clear_inputs();
    bus4.out_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus4.in_flat_valid = 4'hF;
    bus4.in_flat_first = 4'hF;
    bus4.in_flat_last  = 4'hF;
    bus4.in_flat_data  = 64'($urandom) | (64'($urandom) << 32);
    bus4.out_ready     = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus4.in_flat_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b expected 0000", bus4.in_flat_ready); end
    checks++; if (bus4.grant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b expected 0000", bus4.grant); end
    checks++; if (bus4.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus4.busy); end
    checks++; if (bus4.out_valid !== 1'b0 || bus4.out_first !== 1'b0 || bus4.out_last !== 1'b0) begin fails++; $display("FAIL reset_outq: got v%b f%b l%b expected 000", bus4.out_valid, bus4.out_first, bus4.out_last); end
    checks++; if (bus4.out_data !== 16'h0000) begin fails++; $display("FAIL reset_data: got %h expected 0000", bus4.out_data); end
    checks++; if (bus2.grant !== 2'b00 || bus2.in_flat_ready !== 2'b00) begin fails++; $display("FAIL reset_p2: got grant %b ready %b expected 00 00", bus2.grant, bus2.in_flat_ready); end
  endtask

  task automatic test_single_packet();
    do_reset();
    drive_beat(0, 1'b1, 1'b1, 1'b0, 16'h0A01);
    #1;
    checks++; if (bus2.grant !== 2'b00 || bus2.busy !== 1'b0) begin fails++; $display("FAIL single_idle: got grant %b busy %b expected 00 0", bus2.grant, bus2.busy); end
    @(negedge clk); #1;
    checks++; if (bus2.grant !== 2'b01 || bus2.busy !== 1'b1) begin fails++; $display("FAIL single_grant: got grant %b busy %b expected 01 1", bus2.grant, bus2.busy); end
    checks++; if (bus2.in_flat_ready !== 2'b01 || bus2.out_valid !== 1'b0) begin fails++; $display("FAIL single_ready: got ready %b ov %b expected 01 0", bus2.in_flat_ready, bus2.out_valid); end
    @(negedge clk);
    drive_beat(0, 1'b1, 1'b0, 1'b0, 16'h0A02);
    #1;
    checks++; if (bus2.out_valid !== 1'b1 || bus2.out_data !== 16'h0A01 || bus2.out_first !== 1'b1 || bus2.out_last !== 1'b0) begin fails++; $display("FAIL single_beat1: got v%b %h f%b l%b expected v1 0a01 f1 l0", bus2.out_valid, bus2.out_data, bus2.out_first, bus2.out_last); end
    @(negedge clk);
    drive_beat(0, 1'b1, 1'b0, 1'b1, 16'h0A03);
    #1;
    checks++; if (bus2.out_valid !== 1'b1 || bus2.out_data !== 16'h0A02 || bus2.out_first !== 1'b0 || bus2.out_last !== 1'b0) begin fails++; $display("FAIL single_beat2: got v%b %h f%b l%b expected v1 0a02 f0 l0", bus2.out_valid, bus2.out_data, bus2.out_first, bus2.out_last); end
    @(negedge clk);
    drive_beat(0, 1'b1, 1'b1, 1'b1, 16'h0B00);
    drive_beat(1, 1'b1, 1'b1, 1'b1, 16'h0B01);
    #1;
    checks++; if (bus2.out_valid !== 1'b1 || bus2.out_data !== 16'h0A03 || bus2.out_first !== 1'b0 || bus2.out_last !== 1'b1) begin fails++; $display("FAIL single_beat3: got v%b %h f%b l%b expected v1 0a03 f0 l1", bus2.out_valid, bus2.out_data, bus2.out_first, bus2.out_last); end
    checks++; if (bus2.busy !== 1'b0 || bus2.grant !== 2'b00) begin fails++; $display("FAIL single_release: got busy %b grant %b expected 0 00", bus2.busy, bus2.grant); end
    @(negedge clk); #1;
    // rr_ptr has moved to 1, so port 1 wins with both ports valid.
    checks++; if (bus2.grant !== 2'b10 || bus2.out_valid !== 1'b0) begin fails++; $display("FAIL single_rrptr: got grant %b ov %b expected 10 0", bus2.grant, bus2.out_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  eg [10];
    logic        ev [10];
    logic [15:0] ed [10];
    int          pkt  [2];
    int          beat [2];
    logic [1:0]  acc;
    eg = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    ev = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ed = '{16'h0, 16'h0, 16'h0000, 16'h0001, 16'h0, 16'h1000, 16'h1001, 16'h0, 16'h0100, 16'h0101};
    pkt  = '{0, 0};
    beat = '{0, 0};
    acc  = '0;
    do_reset();
    for (int n = 0; n < 10; n++) begin
      if (n > 0) @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          beat[p]++;
          if (beat[p] == 2) begin beat[p] = 0; pkt[p]++; end
        end
        drive_beat(p, 1'b1, beat[p] == 0, beat[p] == 1, {4'(p), 4'(pkt[p]), 8'(beat[p])});
      end
      #1;
      acc = bus2.in_flat_valid & bus2.in_flat_ready;
      checks++; if (bus2.grant !== eg[n]) begin fails++; $display("FAIL rr_grant[%0d]: got %b expected %b", n, bus2.grant, eg[n]); end
      checks++; if (bus2.out_valid !== ev[n]) begin fails++; $display("FAIL rr_valid[%0d]: got %b expected %b", n, bus2.out_valid, ev[n]); end
      if (ev[n]) begin
        checks++; if (bus2.out_data !== ed[n] || bus2.out_first !== (ed[n][7:0] == 8'd0) || bus2.out_last !== (ed[n][7:0] == 8'd1)) begin fails++; $display("FAIL rr_beat[%0d]: got %h f%b l%b expected %h", n, bus2.out_data, bus2.out_first, bus2.out_last, ed[n]); end
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive_beat(2, 1'b1, 1'b1, 1'b1, 16'h2222);
    @(negedge clk); #1;
    checks++; if (bus4.grant !== 4'b0100) begin fails++; $display("FAIL wrap_first: got %b expected 0100", bus4.grant); end
    @(negedge clk);
    drive_beat(2, 1'b0, 1'b0, 1'b0, 16'h0);
    drive_beat(0, 1'b1, 1'b1, 1'b1, 16'h0C00);
    drive_beat(3, 1'b1, 1'b1, 1'b1, 16'h3C03);
    #1;
    checks++; if (bus4.busy !== 1'b0 || bus4.out_data !== 16'h2222) begin fails++; $display("FAIL wrap_release: got busy %b data %h expected 0 2222", bus4.busy, bus4.out_data); end
    @(negedge clk); #1;
    checks++; if (bus4.grant !== 4'b1000 || bus4.in_flat_ready !== 4'b1000) begin fails++; $display("FAIL wrap_p3: got grant %b ready %b expected 1000 1000", bus4.grant, bus4.in_flat_ready); end
    @(negedge clk);
    drive_beat(3, 1'b0, 1'b0, 1'b0, 16'h0);
    #1;
    checks++; if (bus4.grant !== 4'b0000 || bus4.out_data !== 16'h3C03) begin fails++; $display("FAIL wrap_p3done: got grant %b data %h expected 0000 3c03", bus4.grant, bus4.out_data); end
    @(negedge clk); #1;
    checks++; if (bus4.grant !== 4'b0001) begin fails++; $display("FAIL wrap_to0: got %b expected 0001", bus4.grant); end
  endtask

  task automatic test_backpressure();
    logic        orr [11];
    logic        er  [11];
    logic        ev  [11];
    logic [15:0] ed  [11];
    int          b;
    logic        acc;
    orr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    er  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ev  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ed  = '{16'h0, 16'h0, 16'h1100, 16'h0, 16'h1101, 16'h1101, 16'h1101, 16'h1101, 16'h1101, 16'h1102, 16'h1103};
    b   = 0;
    acc = 1'b0;
    do_reset();
    for (int n = 0; n < 11; n++) begin
      if (n > 0) @(negedge clk);
      if (acc) b++;
      bus4.out_ready = orr[n];
      drive_beat(1, (n != 2) && (b < 4), b == 0, b == 3, 16'h1100 + 16'(b));
      #1;
      acc = bus4.in_flat_valid[1] && bus4.in_flat_ready[1];
      checks++; if (bus4.in_flat_ready !== {2'b00, er[n], 1'b0}) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected %b", n, bus4.in_flat_ready, {2'b00, er[n], 1'b0}); end
      checks++; if (bus4.out_valid !== ev[n]) begin fails++; $display("FAIL bp_valid[%0d]: got %b expected %b", n, bus4.out_valid, ev[n]); end
      if (ev[n]) begin
        checks++; if (bus4.out_data !== ed[n] || bus4.out_first !== (ed[n][3:0] == 4'd0) || bus4.out_last !== (ed[n][3:0] == 4'd3)) begin fails++; $display("FAIL bp_beat[%0d]: got %h f%b l%b expected %h", n, bus4.out_data, bus4.out_first, bus4.out_last, ed[n]); end
      end
    end
    bus4.out_ready = 1'b1;
  endtask

  task automatic test_valid_drop();
    do_reset();
    drive_beat(0, 1'b1, 1'b1, 1'b0, 16'hD000);
    drive_beat(2, 1'b1, 1'b1, 1'b1, 16'h2D00);
    @(negedge clk); #1;
    checks++; if (bus4.grant !== 4'b0001) begin fails++; $display("FAIL drop_grant: got %b expected 0001", bus4.grant); end
    @(negedge clk);
    drive_beat(0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      checks++; if (bus4.grant !== 4'b0001 || bus4.busy !== 1'b1 || bus4.in_flat_ready !== 4'b0001) begin fails++; $display("FAIL drop_hold[%0d]: got grant %b busy %b ready %b expected 0001 1 0001", k, bus4.grant, bus4.busy, bus4.in_flat_ready); end
    end
    @(negedge clk);
    drive_beat(0, 1'b1, 1'b0, 1'b0, 16'hD001);
    @(negedge clk);
    drive_beat(0, 1'b1, 1'b0, 1'b1, 16'hD002);
    #1;
    checks++; if (bus4.out_valid !== 1'b1 || bus4.out_data !== 16'hD001) begin fails++; $display("FAIL drop_resume: got v%b %h expected v1 d001", bus4.out_valid, bus4.out_data); end
    @(negedge clk);
    drive_beat(0, 1'b0, 1'b0, 1'b0, 16'h0);
    #1;
    checks++; if (bus4.out_data !== 16'hD002 || bus4.out_last !== 1'b1 || bus4.grant !== 4'b0000) begin fails++; $display("FAIL drop_done: got %h l%b grant %b expected d002 l1 0000", bus4.out_data, bus4.out_last, bus4.grant); end
    @(negedge clk); #1;
    checks++; if (bus4.grant !== 4'b0100) begin fails++; $display("FAIL drop_next: got %b expected 0100", bus4.grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_beat(1, 1'b1, 1'b1, 1'b1, 16'h5101);
    @(negedge clk); @(negedge clk);
    drive_beat(1, 1'b0, 1'b0, 1'b0, 16'h0);
    drive_beat(2, 1'b1, 1'b1, 1'b0, 16'h5200);
    @(negedge clk); #1;
    checks++; if (bus4.grant !== 4'b0100) begin fails++; $display("FAIL rmid_lock: got %b expected 0100", bus4.grant); end
    @(negedge clk);
    drive_beat(2, 1'b1, 1'b0, 1'b0, 16'h5201);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus4.out_valid !== 1'b0 || bus4.out_data !== 16'h0 || bus4.out_first !== 1'b0 || bus4.out_last !== 1'b0) begin fails++; $display("FAIL rmid_out: got v%b %h f%b l%b expected all 0", bus4.out_valid, bus4.out_data, bus4.out_first, bus4.out_last); end
    checks++; if (bus4.grant !== 4'b0000 || bus4.busy !== 1'b0 || bus4.in_flat_ready !== 4'b0000) begin fails++; $display("FAIL rmid_ctl: got grant %b busy %b ready %b expected 0000 0 0000", bus4.grant, bus4.busy, bus4.in_flat_ready); end
    clear_inputs();
    drive_beat(1, 1'b1, 1'b1, 1'b1, 16'h6101);
    drive_beat(3, 1'b1, 1'b1, 1'b1, 16'h6303);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus4.grant !== 4'b0010) begin fails++; $display("FAIL rmid_regrant: got %b expected 0010", bus4.grant); end
  endtask

  // Random traffic against a transaction-level model: an owner port (or none),
  // a round-robin start index and the beat currently held at the output.
  task automatic test_random();
    int          owner;
    int          rr;
    int          seq;
    int          len;
    int          pending;
    beat_t       held;
    logic        held_v;
    logic [3:0]  vld;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_grant;
    beat_t       bt;
    owner  = -1;
    rr     = 0;
    held   = '0;
    held_v = 1'b0;
    seq    = 0;
    pending = 0;
    for (int p = 0; p < 4; p++) begin
      srcq[p].delete();
      for (int k = 0; k < 25; k++) begin
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) begin
          bt.d = {4'(p), 12'(seq)};
          bt.f = (b == 0);
          bt.l = (b == len - 1);
          srcq[p].push_back(bt);
          seq++;
          pending++;
        end
      end
    end
    do_reset();
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (pending == 0 && !held_v && owner < 0) break;
      if (cyc > 0) @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        vld[p] = (srcq[p].size() > 0) && ($urandom_range(3) != 0);
        if (vld[p]) drive_beat(p, 1'b1, srcq[p][0].f, srcq[p][0].l, srcq[p][0].d);
        else        drive_beat(p, 1'b0, 1'b0, 1'b0, 16'h0);
      end
      bus4.out_ready = ($urandom_range(3) != 0);
      #1;
      exp_ready = '0;
      exp_grant = '0;
      if (owner >= 0) begin
        exp_grant[owner] = 1'b1;
        exp_ready[owner] = !held_v || bus4.out_ready;
      end
      checks++; if (bus4.in_flat_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, bus4.in_flat_ready, exp_ready); end
      checks++; if (bus4.grant !== exp_grant || bus4.busy !== (owner >= 0)) begin fails++; $display("FAIL rnd_grant[%0d]: got %b busy %b expected %b", cyc, bus4.grant, bus4.busy, exp_grant); end
      checks++; if (bus4.out_valid !== held_v) begin fails++; $display("FAIL rnd_valid[%0d]: got %b expected %b", cyc, bus4.out_valid, held_v); end
      if (held_v) begin
        checks++; if (bus4.out_data !== held.d || bus4.out_first !== held.f || bus4.out_last !== held.l) begin fails++; $display("FAIL rnd_beat[%0d]: got %h f%b l%b expected %h f%b l%b", cyc, bus4.out_data, bus4.out_first, bus4.out_last, held.d, held.f, held.l); end
      end
      // Advance the model across the coming rising edge.
      if (owner >= 0 && vld[owner] && exp_ready[owner]) begin
        held   = srcq[owner].pop_front();
        held_v = 1'b1;
        pending--;
        if (held.l) begin
          rr    = (owner + 1) % 4;
          owner = -1;
        end
      end else begin
        if (bus4.out_ready) held_v = 1'b0;
        if (owner < 0) begin
          for (int k = 0; k < 4; k++) begin
            if (owner < 0 && vld[(rr + k) % 4]) owner = (rr + k) % 4;
          end
        end
      end
    end
    checks++; if (pending != 0) begin fails++; $display("FAIL rnd_drain: got %0d beats outstanding expected 0", pending); end
    clear_inputs();
    bus4.out_ready = 1'b1;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b0;
    clear_inputs();
    bus4.out_ready = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_valid_drop();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dii_packet_arbiter.md
DII_PACKET_ARBITER -- requirements
Module: dii_packet_arbiter

Interface
REQ-001 Parameter PORTS, default 2: number of requesting DII input streams; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; asserts immediately, deasserts synchronously to clk.
REQ-004 in_flat_data  input  PORTS*16  per-port beat data; port i occupies bits [(i+1)*16-1:i*16].
REQ-005 in_flat_valid  input  PORTS  per-port beat valid.
REQ-006 in_flat_first  input  PORTS  per-port first-beat-of-packet flag.
REQ-007 in_flat_last  input  PORTS  per-port last-beat-of-packet flag.
REQ-008 in_flat_ready  output  PORTS  per-port beat accepted when valid and ready are both 1.
REQ-009 out_data  output  16  arbitrated beat data.
REQ-010 out_valid, out_first, out_last  output  1 each  arbitrated beat qualifiers.
REQ-011 out_ready  input  1  downstream acceptance.
REQ-012 grant  output  PORTS  one-hot owner of the output; all-zero when no packet is locked.
REQ-013 busy  output  1  high while in LOCKED state.

Function
REQ-014 Two-state FSM: IDLE and LOCKED.
REQ-015 IDLE: all in_flat_ready = 0; if any in_flat_valid = 1, select the first valid port at or after rr_ptr (modulo PORTS), load it into grant, and go to LOCKED on the next edge.
REQ-016 Selection uses in_flat_valid only; first flags are not checked and are forwarded unmodified.
REQ-017 LOCKED: in_flat_ready[g] = skid_ready for granted port g; all other ports see ready = 0.
REQ-018 Output is a single-entry pipeline register; skid_ready = !out_valid || out_ready.
REQ-019 A granted beat accepted at edge t appears on out_* after edge t; latency exactly 1 cycle; sustained throughput 1 beat/cycle while out_ready = 1.
REQ-020 The out_* register loads data/first/last/valid only on an accepted input beat; otherwise out_valid clears on out_ready = 1 and holds on out_ready = 0 with data stable.
REQ-021 Acceptance of a granted beat with last = 1: next state IDLE, grant cleared, rr_ptr = (g+1) mod PORTS (wraps from PORTS-1 to 0).
REQ-022 The output register drains independently of the FSM; an IDLE-to-LOCKED transition occurs even while a beat is still held.
REQ-023 Packet lock is never preempted: the granted port dropping valid mid-packet holds grant and state indefinitely.
REQ-024 Beats with first = 1 and last = 1 are one-beat packets; they release grant after one acceptance.
REQ-025 Arbitration cost: one bubble cycle (IDLE) between consecutive packets.
REQ-026 PORTS = 1: rr_ptr stays 0; behaviour is otherwise identical.
REQ-027 Non-granted inputs never see ready = 1; no beat is dropped or duplicated.

Reset
REQ-028 While rst = 0: state IDLE, rr_ptr = 0, grant = 0, busy = 0, out_valid = 0, out_first = 0, out_last = 0, out_data = 0, in_flat_ready = 0.
REQ-029 Reset mid-packet discards the held beat and the lock; the next grant after reset follows REQ-015 from rr_ptr = 0.

Verification
REQ-030 PORTS = 2, port 0 sends a 3-beat packet 0x0A01/0x0A02/0x0A03 with out_ready = 1 -> grant = 01 after one cycle; out_data 0x0A01, 0x0A02, 0x0A03 on three consecutive cycles, first on beat 1, last on beat 3; then busy = 0 and rr_ptr = 1.
REQ-031 Ports 0 and 1 both valid continuously with 2-beat packets -> grant alternates 01, 10, 01; each packet has no interleaved beats; one idle cycle between packets.
REQ-032 PORTS = 4, rr_ptr = 3, ports 0 and 3 valid -> port 3 granted; after its last beat, rr_ptr wraps to 0 and port 0 is granted next.
REQ-033 out_ready = 0 for 5 cycles mid-packet -> out_data/out_first/out_last held constant; exactly one further beat accepted (skid full), then in_flat_ready = 0 until out_ready = 1; no loss.
REQ-034 Granted port drops valid for 4 cycles mid-packet while another port is valid -> grant unchanged, other port's ready stays 0; the packet completes on resume.
REQ-035 rst pulled low asynchronously during beat 2 of a packet -> all outputs 0 within the same cycle; after release the first valid port from index 0 is granted.
